la_mux4sel: RTL and testbench

- Time-division select sequencer that sits directly upstream of the 4-input mux and drives its s0/s1 selects.
- Steps through the enabled lanes (0..3) in ascending order, wrapping 3->0, and holds each lane for a programmable dwell time.
- Provides a force/hold override, a valid qualifier and a frame-start pulse, so downstream logic can sample the mux output as a time-multiplexed stream.

---
 rtl/la_mux4sel.sv | 164 ++++++++++++++++
 tb/tb_la_mux4sel.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/la_mux4sel.sv
// Time-division select sequencer driving the s0/s1 selects of a 4-input mux.
// Optional break-before-make dead cycle on lane changes: define LA_MUX4SEL_BREAK_EN.
// The override request port is named force_req because "force" is a reserved word.
module la_mux4sel #(
   parameter string       PROP = "DEFAULT",
   parameter int unsigned CW   = 8
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          en,
   input  logic [3:0]    mask,
   input  logic [CW-1:0] dwell,
   input  logic          force_req,
   input  logic [1:0]    force_sel,
   output logic          s0,
   output logic          s1,
   output logic          valid,
   output logic          frame
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // Reject configurations that cannot map onto a target cell set.
   if (CW < 1 || PROP == "") begin : g_bad_cfg
      $error("la_mux4sel: CW must be >= 1 and PROP must be non-empty");
   end

   state_t        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          frame_q, frame_d;
   logic [1:0]    bnd_lane_c;
   logic [1:0]    start_lane_c;
   logic          go_c;
   logic          at_bnd_c;
`ifdef LA_MUX4SEL_BREAK_EN
   logic [1:0]    nxt_q, nxt_d;
`endif

   // First set mask bit strictly after cur, ascending with 3->0 wrap; cur itself is tried last.
   function automatic logic [1:0] next_lane(input logic [1:0] cur, input logic [3:0] m);
      logic [1:0] lane;
      logic [1:0] cand;
      logic       found;
      lane  = cur;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cand = cur + 2'(i);
         if (!found && m[cand]) begin
            lane  = cand;
            found = 1'b1;
         end
      end
      return lane;
   endfunction

   assign bnd_lane_c   = next_lane(sel_q, mask);
   assign start_lane_c = next_lane(2'd3, mask);
   assign go_c         = en && (mask != 4'b0000);

   // Next-state and next-output decode; force overrides every state.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      frame_d  = 1'b0;
      at_bnd_c = 1'b0;
`ifdef LA_MUX4SEL_BREAK_EN
      nxt_d    = nxt_q;
`endif
      if (force_req) begin
         state_d = ST_HOLD;
         sel_d   = force_sel;
         valid_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (go_c) begin
                  state_d = ST_RUN;
                  sel_d   = start_lane_c;
                  cnt_d   = dwell;
                  valid_d = 1'b1;
                  frame_d = 1'b1;
               end else begin
                  valid_d = 1'b0;
               end
            end
            ST_RUN: begin
               if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
               else             at_bnd_c = 1'b1;
            end
            ST_HOLD: at_bnd_c = 1'b1;
`ifdef LA_MUX4SEL_BREAK_EN
            ST_GAP: begin
               state_d = ST_RUN;
               sel_d   = nxt_q;
               cnt_d   = dwell;
               valid_d = 1'b1;
               frame_d = (nxt_q <= sel_q);
            end
`endif
            default: begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         endcase

         // Slot boundary: en/mask are only sampled here.
         if (at_bnd_c) begin
            if (!go_c) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
`ifdef LA_MUX4SEL_BREAK_EN
            end else if (bnd_lane_c != sel_q) begin
               state_d = ST_GAP;
               valid_d = 1'b0;
               nxt_d   = bnd_lane_c;
`endif
            end else begin
               state_d = ST_RUN;
               sel_d   = bnd_lane_c;
               cnt_d   = dwell;
               valid_d = 1'b1;
               frame_d = (bnd_lane_c <= sel_q);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'b00;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         frame_q <= 1'b0;
`ifdef LA_MUX4SEL_BREAK_EN
         nxt_q   <= 2'b00;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         frame_q <= frame_d;
`ifdef LA_MUX4SEL_BREAK_EN
         nxt_q   <= nxt_d;
`endif
      end
   end

   assign s0    = sel_q[0];
   assign s1    = sel_q[1];
   assign valid = valid_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_la_mux4sel.sv
// Directed scoreboard bench for la_mux4sel; expected {sel,valid,frame} per cycle.
module tb_la_mux4sel;

   localparam int unsigned CW = 8;

   typedef struct packed {
      logic [1:0] sel;
      logic       valid;
      logic       frame;
   } exp_t;

   logic          clk;
   logic          nreset;
   logic          en;
   logic [3:0]    mask;
   logic [CW-1:0] dwell;
   logic          force_req;
   logic [1:0]    force_sel;
   logic          s0, s1, valid, frame;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   step_no = 0;

   la_mux4sel #(.PROP("DEFAULT"), .CW(CW)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .en        (en),
      .mask      (mask),
      .dwell     (dwell),
      .force_req (force_req),
      .force_sel (force_sel),
      .s0        (s0),
      .s1        (s1),
      .valid     (valid),
      .frame     (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s step %0d: observed=%0h expected=%0h", tag, step_no, obs, expv);
      end
   endtask

   // Push expectation, advance one edge, pop and compare the registered outputs.
   task automatic cyc(input logic [1:0] es, input logic ev, input logic ef);
      exp_t e;
      exp_q.push_back('{sel: es, valid: ev, frame: ef});
      @(posedge clk);
      #1;
      step_no++;
      e = exp_q.pop_front();
      check("sel",   {2'b00, s1, s0}, {2'b00, e.sel});
      check("valid", {3'b000, valid}, {3'b000, e.valid});
      check("frame", {3'b000, frame}, {3'b000, e.frame});
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_sel"},   {2'b00, s1, s0}, 4'h0);
      check({tag, "_valid"}, {3'b000, valid}, 4'h0);
      check({tag, "_frame"}, {3'b000, frame}, 4'h0);
   endtask

   initial begin
      nreset = 1'b0; en = 1'b0; mask = 4'b0000; dwell = '0;
      force_req = 1'b0; force_sel = 2'b00;
      #2;
      check_reset_outs("por");
      @(negedge clk); @(negedge clk);
      nreset = 1'b1;
      cyc(2'd0, 1'b0, 1'b0);

`ifndef LA_MUX4SEL_BREAK_EN
      // All lanes, one cycle per slot.
      en = 1'b1; mask = 4'b1111; dwell = 8'd0;
      cyc(2'd0, 1, 1); cyc(2'd1, 1, 0); cyc(2'd2, 1, 0); cyc(2'd3, 1, 0);
      cyc(2'd0, 1, 1); cyc(2'd1, 1, 0);
      en = 1'b0;
      cyc(2'd1, 0, 0); cyc(2'd1, 0, 0);

      // Lanes 1 and 3, three cycles per slot; mask change mid-slot.
      en = 1'b1; mask = 4'b1010; dwell = 8'd2;
      cyc(2'd1, 1, 1); cyc(2'd1, 1, 0); cyc(2'd1, 1, 0);
      cyc(2'd3, 1, 0); cyc(2'd3, 1, 0); cyc(2'd3, 1, 0);
      cyc(2'd1, 1, 1);
      mask = 4'b0100;
      cyc(2'd1, 1, 0); cyc(2'd1, 1, 0);
      cyc(2'd2, 1, 0); cyc(2'd2, 1, 0); cyc(2'd2, 1, 0);
      cyc(2'd2, 1, 1); cyc(2'd2, 1, 0); cyc(2'd2, 1, 0);
      cyc(2'd2, 1, 1);

      // Force override then release into lane 3 with a full dwell.
      mask = 4'b1111; force_req = 1'b1; force_sel = 2'd2;
      for (int i = 0; i < 5; i++) cyc(2'd2, 1, 0);
      force_req = 1'b0;
      cyc(2'd3, 1, 0); cyc(2'd3, 1, 0); cyc(2'd3, 1, 0);
      cyc(2'd0, 1, 1);

      // en dropped two cycles into a six-cycle slot.
      dwell = 8'd5;
      cyc(2'd0, 1, 0); cyc(2'd0, 1, 0);
      cyc(2'd1, 1, 0); cyc(2'd1, 1, 0); cyc(2'd1, 1, 0);
      en = 1'b0;
      cyc(2'd1, 1, 0); cyc(2'd1, 1, 0); cyc(2'd1, 1, 0);
      cyc(2'd1, 0, 0); cyc(2'd1, 0, 0);

      // mask cleared mid-slot behaves like en low at the boundary.
      en = 1'b1;
      cyc(2'd0, 1, 1); cyc(2'd0, 1, 0); cyc(2'd0, 1, 0);
      mask = 4'b0000;
      cyc(2'd0, 1, 0); cyc(2'd0, 1, 0); cyc(2'd0, 1, 0);
      cyc(2'd0, 0, 0);

      // Asynchronous reset mid-slot on lane 3.
      mask = 4'b1000;
      cyc(2'd3, 1, 1); cyc(2'd3, 1, 0);
      nreset = 1'b0;
      #2;
      check_reset_outs("async_rst");
      @(negedge clk);
      nreset = 1'b1;
      mask = 4'b0110;
      cyc(2'd1, 1, 1);

      // Own lane masked at boundary; dwell change only at next load.
      mask = 4'b0101; dwell = 8'd0;
      for (int i = 0; i < 5; i++) cyc(2'd1, 1, 0);
      cyc(2'd2, 1, 0); cyc(2'd0, 1, 1); cyc(2'd2, 1, 0); cyc(2'd0, 1, 1);

      // Maximum dwell: 256-cycle slot on a single lane.
      mask = 4'b0001; dwell = 8'd255;
      cyc(2'd0, 1, 1);
      for (int i = 0; i < 255; i++) cyc(2'd0, 1, 0);
      cyc(2'd0, 1, 1);

      // force_sel tracking in HOLD, exit to IDLE, force from IDLE.
      force_req = 1'b1; force_sel = 2'd3;
      cyc(2'd3, 1, 0);
      force_sel = 2'd1;
      cyc(2'd1, 1, 0);
      force_req = 1'b0; en = 1'b0;
      cyc(2'd1, 0, 0);
      force_req = 1'b1; force_sel = 2'd2;
      cyc(2'd2, 1, 0);
      force_req = 1'b0; en = 1'b1; dwell = 8'd0;
      cyc(2'd0, 1, 1); cyc(2'd0, 1, 1);
`else
      // Break-before-make: dead cycle between lanes 0 and 1.
      en = 1'b1; mask = 4'b0011; dwell = 8'd1;
      cyc(2'd0, 1, 1); cyc(2'd0, 1, 0); cyc(2'd0, 0, 0);
      cyc(2'd1, 1, 0); cyc(2'd1, 1, 0); cyc(2'd1, 0, 0);
      cyc(2'd0, 1, 1); cyc(2'd0, 1, 0); cyc(2'd0, 0, 0);
      cyc(2'd1, 1, 0); cyc(2'd1, 1, 0);
      cyc(2'd1, 0, 0);
      force_req = 1'b1; force_sel = 2'd3;
      cyc(2'd3, 1, 0);
      force_req = 1'b0;
      cyc(2'd3, 0, 0); cyc(2'd0, 1, 1);
      mask = 4'b0001;
      cyc(2'd0, 1, 0); cyc(2'd0, 1, 1); cyc(2'd0, 1, 0); cyc(2'd0, 1, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
